vga_scan_pipeline: RTL
======================

// Module: vga_scan_pipeline
// PURPOSE
//  Parametrised VGA raster engine; successor to the fixed 128x96/3-bit controller.
//  - Generates H/V timing from a configurable divided pixel tick.
//  - Issues linear framebuffer read addresses, with pixel replication by 2^SCALE_LOG2.
//  - Delays sync and blanking to match a configurable VRAM read latency.
//  - Drives CH_BITS-per-channel RGB and a frame-synchronous blank control.
//  - Sits between the reset synchroniser/debouncer and the VRAM read port.
// PARAMETERS
//  H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48   - horizontal timing, in pixels
//  V_ACTIVE 480 | V_FP 10 | V_SYNC 2  | V_BP 33   - vertical timing, in lines
//  HS_POL 0, VS_POL 0  - active level of hsync/vsync
//  CLK_DIV 4           - clk cycles per pixel (>=1)
//  SCALE_LOG2 3        - each framebuffer cell spans 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels
//  CH_BITS 1           - bits per colour channel
//  RD_LAT 2            - VRAM read latency, clk cycles (>=1)
//  ADDR_W 13           - read address width; must satisfy 2^ADDR_W >= FB_W*FB_H (elaboration check)
// PORTS
//  clk          in   1          system clock
//  reset        in   1          synchronous, active-high
//  rd_addr      out  ADDR_W     VRAM read address
//  rd_en        out  1          rd_addr is valid (active area)
//  rd_data      in   3*CH_BITS  {R,G,B}; valid RD_LAT cycles after address
//  blank_req    in   1          force black; sampled once per frame
//  vga_red      out  CH_BITS
//  vga_green    out  CH_BITS
//  vga_blue     out  CH_BITS
//  vga_hsync    out  1
//  vga_vsync    out  1
//  frame_start  out  1          1-clk pulse at start of each new frame
// BEHAVIOUR
//  - Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//    FB_W=H_ACTIVE>>SCALE_LOG2; FB_H=V_ACTIVE>>SCALE_LOG2.
//  - Tick: divider counts 0..CLK_DIV-1; tick asserts when it equals CLK_DIV-1. CLK_DIV=1 ticks every clk.
//  - Counters: hcnt advances on tick, wrapping H_TOTAL-1 -> 0. vcnt advances on a tick where hcnt wraps,
//    wrapping V_TOTAL-1 -> 0. Each position is held for exactly CLK_DIV clk cycles.
//  - Stage 0 (combinational from counter regs):
//    - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
//    - hs_raw = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_raw is the same form on vcnt.
//    - rd_en = active; rd_addr = row_base + (hcnt>>SCALE_LOG2) when active, else 0.
//  - row_base: no multiplier.
//    - Cleared when vcnt wraps to 0.
//    - += FB_W on a vcnt increment whose new value has low SCALE_LOG2 bits all 0 and is < V_ACTIVE.
//  - Delay line: {active, hs_raw, vs_raw} delayed RD_LAT clk cycles, then captured in output regs
//    together with rd_data.
//    - Pin latency = RD_LAT+1 clk cycles from the counter stage. Sync and RGB stay mutually aligned.
//    - Delayed active=0 or blank_frame=1 -> RGB = 0; otherwise RGB = rd_data.
//    - vga_hsync = hs_d ? HS_POL : ~HS_POL; vga_vsync likewise with VS_POL.
//  - frame_start: registered 1-clk pulse on the tick where (hcnt,vcnt)=(H_TOTAL-1,V_TOTAL-1).
//    - Leads the pins by RD_LAT+1 cycles.
//    - Not asserted by reset itself.
//  - blank_frame: loads blank_req on the frame_start cycle only. Mid-frame changes of blank_req
//    have no effect until the next frame.
//  - Reset (any cycle, incl. mid-line):
//    - Next cycle: divider=0, hcnt=vcnt=0, row_base=0, delay line cleared to inactive, blank_frame=0.
//    - Outputs: RGB=0, syncs at inactive level, frame_start=0. rd_en=1 and rd_addr=0 (pixel 0,0
//      restarts immediately).
//    - Pins show stale-free black until the pipeline refills.
//  - Simultaneous tick + reset: reset wins.
// STRUCTURE
//  - vga_pkg: timing defaults (640x480@60), HS/VS polarity constants, function clog2,
//    derived-constant macros.
//  - Sub-module vga_axis_counter (count, wrap, active/sync window decode), instantiated for H and V;
//    the V instance enables on the H wrap.
//  - Top holds divider, row_base, delay line, output regs.
// TESTING (sim params: H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, SCALE_LOG2=1, RD_LAT=2, CH_BITS=1, ADDR_W=3)
//  - Timing: free run 2 frames -> hsync low for 4 clk of every 28, vsync low for 28 clk of 196;
//    frame_start period 196 clk.
//  - Addressing: model VRAM, data=addr -> rd_addr sequence per line 0,0,1,1,2,2,3,3 (each 2 clk);
//    lines 2-3 start at 4; wraps to 0 next frame.
//  - Alignment: VRAM returns 3'b111 only at addr 0 -> RGB high exactly 4 clk on lines 0-1, starting
//    3 clk after rd_addr=0 asserted; never during sync/porch.
//  - Blank: raise blank_req mid-frame -> current frame unaffected; next frame all RGB 0, syncs unchanged.
//  - Reset mid-line at hcnt=5,vcnt=2 -> next clk rd_addr=0, rd_en=1, syncs inactive, RGB=0;
//    first frame_start 196 clk later.
//  - CLK_DIV=1, RD_LAT=1 regression: same checks with halved periods; pin latency 2 clk.

Source files
------------

// File: rtl/vga_scan_pipeline_pkg.sv
// Shared timing defaults, sync polarity constants and elaboration helpers for the VGA raster engine.
package vga_scan_pipeline_pkg;

  // 640x480 @ 60 Hz, 25 MHz pixel rate
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  // Classic VGA modes drive both syncs low while asserted
  localparam logic SyncActiveLow = 1'b0;

  // Control bits that travel down the delay line alongside the VRAM read
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } scan_ctl_t;

  // Bits needed to hold 0..value-1; never less than one so a divide-by-1 still has a register
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'(1) << width) < 64'(value)) width++;
    return width;
  endfunction

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_scan_pipeline_axis_counter.sv
// One raster axis: position counter with wrap, plus active-area and sync-window decode.
module vga_scan_pipeline_axis_counter
  import vga_scan_pipeline_pkg::*;
#(
  parameter int unsigned Active = 8,
  parameter int unsigned Fp     = 2,
  parameter int unsigned Sync   = 2,
  parameter int unsigned Bp     = 2,
  parameter int unsigned Width  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [Width-1:0] cnt,
  output logic             last,
  output logic             active,
  output logic             sync
);

  localparam int unsigned Total     = axis_total(Active, Fp, Sync, Bp);
  localparam int unsigned SyncStart = Active + Fp;
  localparam int unsigned SyncEnd   = SyncStart + Sync;

  logic [Width-1:0] cnt_q;
  logic [31:0]      cnt_ext;

  // Advance one position per enable, wrapping at the end of the axis
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + Width'(1);
    end
  end

  // Decode in 32 bits so window bounds equal to Total cannot alias
  assign cnt_ext = 32'(cnt_q);
  assign cnt     = cnt_q;
  assign last    = (cnt_ext == Total - 1);
  assign active  = (cnt_ext < Active);
  assign sync    = (cnt_ext >= SyncStart) && (cnt_ext < SyncEnd);

endmodule

// File: rtl/vga_scan_pipeline.sv
// VGA raster engine: divided pixel tick, H/V timing, scaled framebuffer addressing and a
// sync/blank delay line matched to the VRAM read latency.
module vga_scan_pipeline
  import vga_scan_pipeline_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter logic        HS_POL     = SyncActiveLow,
  parameter logic        VS_POL     = SyncActiveLow,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter int unsigned CH_BITS    = 1,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_en,
  input  logic [3*CH_BITS-1:0] rd_data,
  input  logic                 blank_req,
  output logic [CH_BITS-1:0]   vga_red,
  output logic [CH_BITS-1:0]   vga_green,
  output logic [CH_BITS-1:0]   vga_blue,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 frame_start
);

  localparam int unsigned H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned FB_W     = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_H     = V_ACTIVE >> SCALE_LOG2;
  localparam int unsigned HW       = clog2(H_TOTAL);
  localparam int unsigned VW       = clog2(V_TOTAL);
  localparam int unsigned DIV_W    = clog2(CLK_DIV);
  localparam int unsigned ROW_MASK = (1 << SCALE_LOG2) - 1;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 1");
  end
  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("RD_LAT must be at least 1");
  end
  if ((64'(1) << ADDR_W) < 64'(FB_W) * 64'(FB_H)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for the framebuffer");
  end

  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [VW-1:0]     v_next;
  logic              h_last, v_last, h_act, v_act, h_sync, v_sync;
  logic              line_end;
  logic              row_step;
  logic [ADDR_W-1:0] row_base_q;
  scan_ctl_t         ctl0;
  scan_ctl_t         ctl_out;
  scan_ctl_t         dly_q [RD_LAT];
  logic [3*CH_BITS-1:0] rgb_q;
  logic              hsync_q, vsync_q, frame_start_q, blank_q;

  // Pixel-rate divider; tick marks the last clk of each pixel position
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end
  assign tick = (32'(div_q) == CLK_DIV - 1);

  vga_scan_pipeline_axis_counter #(
    .Active (H_ACTIVE),
    .Fp     (H_FP),
    .Sync   (H_SYNC),
    .Bp     (H_BP),
    .Width  (HW)
  ) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .en     (tick),
    .cnt    (h_cnt),
    .last   (h_last),
    .active (h_act),
    .sync   (h_sync)
  );

  assign line_end = tick && h_last;

  vga_scan_pipeline_axis_counter #(
    .Active (V_ACTIVE),
    .Fp     (V_FP),
    .Sync   (V_SYNC),
    .Bp     (V_BP),
    .Width  (VW)
  ) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .en     (line_end),
    .cnt    (v_cnt),
    .last   (v_last),
    .active (v_act),
    .sync   (v_sync)
  );

  // Stage 0: address decode straight from the counters
  assign ctl0    = '{active: h_act && v_act, hsync: h_sync, vsync: v_sync};
  assign rd_en   = ctl0.active;
  assign rd_addr = ctl0.active ? row_base_q + ADDR_W'(h_cnt >> SCALE_LOG2) : '0;

  // A new framebuffer row starts every 2^SCALE_LOG2 lines within the active area
  assign v_next   = v_cnt + VW'(1);
  assign row_step = ((32'(v_next) & ROW_MASK) == 0) && (32'(v_next) < V_ACTIVE);

  // Running row base address, built by accumulation instead of vcnt*FB_W
  always_ff @(posedge clk) begin
    if (reset) begin
      row_base_q <= '0;
    end else if (line_end) begin
      if (v_last) begin
        row_base_q <= '0;
      end else if (row_step) begin
        row_base_q <= row_base_q + ADDR_W'(FB_W);
      end
    end
  end

  // Hold sync/active back by the VRAM latency so they meet rd_data at the output regs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= ctl0;
      for (int i = 1; i < RD_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end
  assign ctl_out = dly_q[RD_LAT-1];

  // Output pin registers; black outside the active area or on a blanked frame
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
    end else begin
      rgb_q   <= (ctl_out.active && !blank_q) ? rd_data : '0;
      hsync_q <= ctl_out.hsync ? HS_POL : ~HS_POL;
      vsync_q <= ctl_out.vsync ? VS_POL : ~VS_POL;
    end
  end

  // Frame pulse coincides with the counters sitting at (0,0); blank latches only then
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start_q <= 1'b0;
      blank_q       <= 1'b0;
    end else begin
      frame_start_q <= line_end && v_last;
      if (frame_start_q) blank_q <= blank_req;
    end
  end

  assign vga_red     = rgb_q[3*CH_BITS-1 -: CH_BITS];
  assign vga_green   = rgb_q[2*CH_BITS-1 -: CH_BITS];
  assign vga_blue    = rgb_q[CH_BITS-1:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = frame_start_q;

endmodule
